pipe_ctrl: RTL and testbench

//  Pipeline control unit for the 5-stage Y86-64 pipeline. Each cycle, derives the stall/bubble controls
//  for the F/D/E/M/W pipeline registers from stage icodes, register IDs, branch outcome and status.
//  Run FSM sequences start, run, and halt/exception drain; run-cycle watchdog forces a stop.

---
 rtl/y86_pkg.sv | 38 +++
 rtl/pipe_sat_cnt.sv | 32 +++
 rtl/pipe_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings (icodes, register IDs, status codes) and the run-control state type.
// Pure declarations; no logic or timing of its own.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE   = 4'hF;

  localparam logic [3:0] SAOK    = 4'b1000;
  localparam logic [3:0] SHLT    = 4'b0100;
  localparam logic [3:0] SADR    = 4'b0010;
  localparam logic [3:0] SINS    = 4'b0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } ctrl_state_t;

  // A load in E feeds a source being read in D; RNONE never creates a hazard.
  function automatic logic reg_hazard(input logic [3:0] dst,
                                      input logic [3:0] src_a,
                                      input logic [3:0] src_b);
    return (dst != RNONE) && ((dst == src_a) || (dst == src_b));
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; clr has priority over inc.
// Count visible one cycle after inc; holds at all-ones, never wraps.
module pipe_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline stall/bubble control with IDLE/RUN/STOP sequencing and run-cycle watchdog.
// Controls are same-cycle combinational in RUN; PIPE_PERF_EN adds saturating perf counters on perf_bus.
module pipe_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 0,
  parameter bit START_ON_RST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         D_icode,
  input  logic [3:0]         d_srcA,
  input  logic [3:0]         d_srcB,
  input  logic [3:0]         E_icode,
  input  logic [3:0]         E_dstM,
  input  logic               e_Cnd,
  input  logic [3:0]         M_icode,
  input  logic [3:0]         m_stat,
  input  logic [3:0]         W_icode,
  input  logic [3:0]         W_stat,
  output logic               F_stall,
  output logic               D_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_stall,
  output logic               set_cc,
  output logic               running,
  output logic               halted,
  output logic [3:0]         final_stat,
  output logic               timeout,
  output logic [CNT_W-1:0]   cyc_cnt,
  output logic [3*CNT_W-1:0] perf_bus
);

  import y86_pkg::*;

  localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(MAX_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [3:0]  final_stat_q, final_stat_d;
  logic        timeout_q, timeout_d;
  logic        running_q, running_d;
  logic        halted_q, halted_d;

  logic in_run;
  logic lu, ret, mp, w_bad, m_bad, wd_hit;

  assign in_run = (state_q == RUN);
  assign lu     = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) && reg_hazard(E_dstM, d_srcA, d_srcB);
  assign ret    = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
  assign mp     = (E_icode == IJXX) && !e_Cnd;
  assign w_bad  = (W_stat != SAOK);
  assign m_bad  = (m_stat != SAOK);
  assign wd_hit = (MAX_CYCLES != 0) && (cyc_cnt == WD_LIM);

  always_comb begin
    state_d      = state_q;
    final_stat_d = final_stat_q;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: if (start || START_ON_RST) state_d = RUN;
      RUN: begin
        if (w_bad || wd_hit) begin
          state_d      = STOP;
          // A faulting W status outranks the watchdog for the reported cause.
          final_stat_d = w_bad ? W_stat : SAOK;
          timeout_d    = wd_hit;
        end
      end
      default: state_d = state_q;
    endcase
    running_d = (state_d == RUN);
    halted_d  = (state_d == STOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      final_stat_q <= SAOK;
      timeout_q    <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      final_stat_q <= final_stat_d;
      timeout_q    <= timeout_d;
      running_q    <= running_d;
      halted_q     <= halted_d;
    end
  end

  // Outside RUN the whole pipe is frozen with NOPs parked in E and M.
  always_comb begin
    F_stall  = 1'b1;
    D_stall  = 1'b1;
    D_bubble = 1'b0;
    E_bubble = 1'b1;
    M_bubble = 1'b1;
    W_stall  = 1'b1;
    set_cc   = 1'b0;
    if (in_run) begin
      F_stall  = lu | ret;
      D_stall  = lu & !mp;
      D_bubble = mp | (ret & !lu);
      E_bubble = mp | lu;
      M_bubble = m_bad | w_bad;
      W_stall  = w_bad;
      set_cc   = (E_icode == IOPQ) && !m_bad && !w_bad;
    end
  end

  assign running    = running_q;
  assign halted     = halted_q;
  assign final_stat = final_stat_q;
  assign timeout    = timeout_q;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk (clk),
    .clr (rst),
    .inc (in_run),
    .q   (cyc_cnt)
  );

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] retired_cnt, stall_cnt, mispred_cnt;

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk (clk),
    .clr (rst),
    .inc (in_run && !w_bad && (W_icode != INOP)),
    .q   (retired_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .inc (in_run && F_stall),
    .q   (stall_cnt)
  );

  pipe_sat_cnt #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk (clk),
    .clr (rst),
    .inc (in_run && mp),
    .q   (mispred_cnt)
  );

  assign perf_bus = {retired_cnt, stall_cnt, mispred_cnt};
`else
  logic unused_w_icode;
  assign unused_w_icode = ^W_icode;
  assign perf_bus       = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;
  import y86_pkg::*;

  localparam int CNT_W = 32;
  localparam logic [6:0] C_IDLE = 7'b1101110;
  localparam logic [6:0] C_NONE = 7'b0000000;

  logic             clk = 1'b0;
  logic             rst, start, e_Cnd;
  logic [3:0]       D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
  logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
  logic             running, halted, timeout;
  logic [3:0]       final_stat;
  logic [CNT_W-1:0] cyc_cnt;
  logic [3*CNT_W-1:0] perf_bus;

  // Expected control vector order: {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  typedef struct {
    string       nm;
    logic [6:0]  ctl;
    logic        run;
    logic        hlt;
    logic [3:0]  fs;
    logic        to;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  pipe_ctrl #(.CNT_W(CNT_W), .MAX_CYCLES(8), .START_ON_RST(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
    .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
    .running(running), .halted(halted), .final_stat(final_stat), .timeout(timeout),
    .cyc_cnt(cyc_cnt), .perf_bus(perf_bus)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic norm();
    rst = 1'b0; start = 1'b0;
    D_icode = INOP; d_srcA = RNONE; d_srcB = RNONE;
    E_icode = INOP; E_dstM = RNONE; e_Cnd = 1'b0;
    M_icode = INOP; m_stat = SAOK;
    W_icode = INOP; W_stat = SAOK;
  endtask

  task automatic expv(input string nm, input logic [6:0] ctl, input logic run, input logic hlt,
                      input logic [3:0] fs, input logic to, input int unsigned cyc);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.run = run; e.hlt = hlt; e.fs = fs; e.to = to; e.cyc = cyc;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act_ctl;
      e = sb.pop_front();
      act_ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc};
      n_chk++;
      if (act_ctl === e.ctl && running === e.run && halted === e.hlt &&
          final_stat === e.fs && timeout === e.to && cyc_cnt === e.cyc) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got ctl=%b run=%b hlt=%b fs=%b to=%b cyc=%0d, want ctl=%b run=%b hlt=%b fs=%b to=%b cyc=%0d",
                 e.nm, act_ctl, running, halted, final_stat, timeout, cyc_cnt,
                 e.ctl, e.run, e.hlt, e.fs, e.to, e.cyc);
      end
    end
  end

  initial begin
    norm(); rst = 1'b1;
    nxt(); norm(); rst = 1'b1; expv("reset",       C_IDLE, 0, 0, SAOK, 0, 0);
    nxt(); norm();             expv("idle_hold",   C_IDLE, 0, 0, SAOK, 0, 0);
    nxt(); norm(); start = 1;  expv("idle_start",  C_IDLE, 0, 0, SAOK, 0, 0);
    nxt(); norm();             expv("run_nop",     C_NONE, 1, 0, SAOK, 0, 0);
    nxt(); norm(); E_icode = IMRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
                               expv("load_use",    7'b1101000, 1, 0, SAOK, 0, 1);
    nxt(); norm(); D_icode = IRET;
                               expv("ret",         7'b1010000, 1, 0, SAOK, 0, 2);
    nxt(); norm(); D_icode = IRET; E_icode = IPOPQ; E_dstM = 4'h4; d_srcB = 4'h4;
                               expv("ret_lu",      7'b1101000, 1, 0, SAOK, 0, 3);
    nxt(); norm(); E_icode = IJXX; e_Cnd = 1'b0;
                               expv("mispredict",  7'b0011000, 1, 0, SAOK, 0, 4);
    nxt(); norm(); E_icode = IJXX; e_Cnd = 1'b1;
                               expv("jxx_taken",   C_NONE, 1, 0, SAOK, 0, 5);
    nxt(); norm(); E_icode = IOPQ;
                               expv("set_cc",      7'b0000001, 1, 0, SAOK, 0, 6);
    nxt(); norm();             expv("wd_last",     C_NONE, 1, 0, SAOK, 0, 7);
    nxt(); norm();             expv("wd_stop",     C_IDLE, 0, 1, SAOK, 1, 8);
    nxt(); norm(); start = 1;  expv("stop_start",  C_IDLE, 0, 1, SAOK, 1, 8);
    nxt(); norm(); rst = 1;    expv("stop_hold",   C_IDLE, 0, 1, SAOK, 1, 8);
    nxt(); norm(); start = 1;  expv("rst_from_stop", C_IDLE, 0, 0, SAOK, 0, 0);
    nxt(); norm(); E_icode = IOPQ; m_stat = SADR;
                               expv("mstat_bubble", 7'b0000100, 1, 0, SAOK, 0, 0);
    nxt(); norm(); W_stat = SHLT;
                               expv("halt_cycle",  7'b0000110, 1, 0, SAOK, 0, 1);
    nxt(); norm();             expv("halt_stop",   C_IDLE, 0, 1, SHLT, 0, 2);
    nxt(); norm(); rst = 1;    expv("halt_frozen", C_IDLE, 0, 1, SHLT, 0, 2);
    nxt(); norm(); start = 1;  expv("rst2",        C_IDLE, 0, 0, SAOK, 0, 0);
    for (int i = 0; i < 5; i++) begin
      nxt(); norm();
    end
    nxt(); norm(); rst = 1;    expv("pre_rst_c5",  C_NONE, 1, 0, SAOK, 0, 5);
    nxt(); norm(); start = 1;  expv("rst_mid_run", C_IDLE, 0, 0, SAOK, 0, 0);
    nxt(); norm();             expv("resume",      C_NONE, 1, 0, SAOK, 0, 0);
    for (int i = 0; i < 6; i++) begin
      nxt(); norm();
    end
    nxt(); norm(); W_stat = SINS;
                               expv("both_cause",  7'b0000110, 1, 0, SAOK, 0, 7);
    nxt(); norm();             expv("both_stop",   C_IDLE, 0, 1, SINS, 1, 8);
    nxt(); nxt();

    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL sb_drain: got %0d entries left, want 0", sb.size());
`ifndef PIPE_PERF_EN
    n_chk++;
    if (perf_bus === '0) n_pass++;
    else $display("FAIL perf_off: got %h, want 0", perf_bus);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
